f_fetch_ctrl: RTL and testbench

//  Fetch-stage sequencer. Owns the PC and drives a single-outstanding instruction-memory

---
 rtl/f_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_f_fetch_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_ctrl.sv
// Fetch sequencer: owns the PC, one outstanding imem request, presents to decode.
// Optional perf counters when FETCH_PERF_EN is defined.
module f_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        d_ready,
  input  logic        br_en,
  input  logic [31:0] br_addr,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        f_valid,
  output logic [31:0] f_pc_o,
  output logic [31:0] instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_req_pc, w_req_pc;
  logic        r_kill, w_kill;
  logic        r_f_valid, w_f_valid;
  logic [31:0] r_f_pc, w_f_pc;
  logic [31:0] r_instr, w_instr;
  logic        w_drop;
  logic        w_stall;
  logic [31:0] w_br_pc;

  assign w_br_pc = {br_addr[31:2], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_req_pc  <= RESET_PC;
      r_kill    <= 1'b0;
      r_f_valid <= 1'b0;
      r_f_pc    <= RESET_PC;
      r_instr   <= NOP_INSTR;
    end else begin
      r_state   <= w_state;
      r_pc      <= w_pc;
      r_req_pc  <= w_req_pc;
      r_kill    <= w_kill;
      r_f_valid <= w_f_valid;
      r_f_pc    <= w_f_pc;
      r_instr   <= w_instr;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_req_pc  = r_req_pc;
    w_kill    = r_kill;
    w_f_valid = r_f_valid;
    w_f_pc    = r_f_pc;
    w_instr   = r_instr;
    w_drop    = 1'b0;
    w_stall   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_state = S_REQ;
        if (br_en) w_pc = w_br_pc;
      end
      S_REQ: begin
        if (imem_req_ready) begin
          w_req_pc = r_pc;
          w_kill   = br_en;
          w_state  = S_WAIT;
        end
        if (br_en) w_pc = w_br_pc;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_kill  = 1'b0;
          w_state = S_REQ;
          if (r_kill || br_en) begin
            w_drop = 1'b1;
          end else begin
            w_instr   = imem_rsp_data;
            w_f_pc    = r_req_pc;
            w_f_valid = 1'b1;
            w_state   = S_OUT;
          end
          if (br_en) w_pc = w_br_pc;
        end else if (br_en) begin
          w_kill = 1'b1;
          w_pc   = w_br_pc;
        end
      end
      S_OUT: begin
        w_stall = !d_ready;
        // a redirect overrides acceptance, so no +4 in that case
        if (br_en) begin
          w_pc      = w_br_pc;
          w_f_valid = 1'b0;
          w_instr   = NOP_INSTR;
          w_state   = S_REQ;
        end else if (d_ready) begin
          w_pc      = r_pc + 32'd4;
          w_f_valid = 1'b0;
          w_instr   = NOP_INSTR;
          w_state   = S_REQ;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign f_valid        = r_f_valid;
  assign f_pc_o         = r_f_pc;
  assign instr          = r_instr;

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_kill_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_drop && (r_kill_cnt != 32'hFFFF_FFFF))
        r_kill_cnt <= r_kill_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_kill_cnt  = r_kill_cnt;
`else
  logic w_unused;
  assign w_unused = w_drop | w_stall;
`endif

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Bench for f_fetch_ctrl: cycle vector table plus scoreboarded presentations.
// Behavioural imem with configurable response latency.
module tb_f_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        d_ready;
  logic        br_en;
  logic [31:0] br_addr;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        f_valid;
  logic [31:0] f_pc_o;
  logic [31:0] instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 0;

  f_fetch_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .d_ready        (d_ready),
    .br_en          (br_en),
    .br_addr        (br_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .f_valid        (f_valid),
    .f_pc_o         (f_pc_o),
    .instr          (instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  // imem model: one outstanding request, response after lat cycles
  logic        pend;
  logic [31:0] paddr;
  int          cnt;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend  <= 1'b0;
      paddr <= '0;
      cnt   <= 0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend  <= 1'b1;
      paddr <= imem_req_addr;
      cnt   <= lat;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  assign imem_rsp_valid = pend && (cnt == 0);
  assign imem_rsp_data  = mem(paddr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic wait_cond(input bit fv, input string nm);
    int n;
    n = 0;
    while (((fv ? f_valid : imem_req_valid) !== 1'b1) && n < 30) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, required signal high", nm, n);
    end
  endtask

  // scoreboard of expected presentations
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_fv = 1'b0;

  always @(negedge clock) begin
    if (f_valid === 1'b1 && prev_fv !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_present: pc %h instr %h, required none",
                 f_pc_o, instr);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_pc", f_pc_o, mon_e.pc);
        chk("sb_instr", instr, mon_e.ins);
      end
    end
    prev_fv = f_valid;
  end

  typedef struct {
    logic        rv;
    logic [31:0] a;
    logic        fv;
    logic [31:0] fpc;
    logic        dr;
    logic        br;
    logic [31:0] ba;
  } vec_t;

  vec_t vec[17];

  function automatic vec_t mk(input logic rv, input logic [31:0] a,
                              input logic fv, input logic [31:0] fpc,
                              input logic dr, input logic br,
                              input logic [31:0] ba);
    vec_t v;
    v.rv = rv; v.a = a; v.fv = fv; v.fpc = fpc;
    v.dr = dr; v.br = br; v.ba = ba;
    return v;
  endfunction

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem(pc);
    sb.push_back(e);
  endtask

  initial begin
    vec[0]  = mk(0, 32'h000, 0, 32'h000, 1, 0, 0);
    vec[1]  = mk(1, 32'h000, 0, 32'h000, 1, 0, 0);
    vec[2]  = mk(0, 32'h000, 0, 32'h000, 1, 0, 0);
    vec[3]  = mk(0, 32'h000, 1, 32'h000, 1, 0, 0);
    vec[4]  = mk(1, 32'h004, 0, 32'h000, 1, 0, 0);
    vec[5]  = mk(0, 32'h004, 0, 32'h000, 1, 0, 0);
    vec[6]  = mk(0, 32'h004, 1, 32'h004, 1, 0, 0);
    vec[7]  = mk(1, 32'h008, 0, 32'h004, 1, 0, 0);
    vec[8]  = mk(0, 32'h008, 0, 32'h004, 1, 0, 0);
    vec[9]  = mk(0, 32'h008, 1, 32'h008, 1, 1, 32'h40);
    vec[10] = mk(1, 32'h040, 0, 32'h008, 1, 0, 0);
    vec[11] = mk(0, 32'h040, 0, 32'h008, 1, 0, 0);
    vec[12] = mk(0, 32'h040, 1, 32'h040, 1, 1, 32'h200);
    vec[13] = mk(1, 32'h200, 0, 32'h040, 1, 0, 0);
    vec[14] = mk(0, 32'h200, 0, 32'h040, 1, 0, 0);
    vec[15] = mk(0, 32'h200, 1, 32'h200, 1, 0, 0);
    vec[16] = mk(1, 32'h204, 0, 32'h200, 0, 0, 0);

    reset = 1'b0;
    d_ready = 1'b0;
    br_en = 1'b0;
    br_addr = '0;
    imem_req_ready = 1'b1;
    repeat (2) @(negedge clock);
    chkb("rst_req_valid", imem_req_valid, 1'b0);
    chkb("rst_f_valid", f_valid, 1'b0);
    chk("rst_f_pc", f_pc_o, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_addr", imem_req_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
    chk("rst_perf_kill", perf_kill_cnt, 32'h0);
`endif

    push(32'h0); push(32'h4); push(32'h8); push(32'h40); push(32'h200);
    reset = 1'b1;
    d_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chkb($sformatf("v%0d_req_valid", i), imem_req_valid, vec[i].rv);
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, vec[i].a);
      chkb($sformatf("v%0d_f_valid", i), f_valid, vec[i].fv);
      chk($sformatf("v%0d_f_pc", i), f_pc_o, vec[i].fpc);
      if (!vec[i].fv) chk($sformatf("v%0d_nop", i), instr, NOP);
      d_ready = vec[i].dr;
      br_en   = vec[i].br;
      br_addr = vec[i].ba;
      @(negedge clock);
    end

    // decode stall
    push(32'h204);
    wait_cond(1'b1, "stall_present");
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chkb("stall_f_valid", f_valid, 1'b1);
      chk("stall_f_pc", f_pc_o, 32'h204);
      chk("stall_instr", instr, mem(32'h204));
      chkb("stall_no_req", imem_req_valid, 1'b0);
    end
`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall_cnt, 32'd5);
`endif
    d_ready = 1'b1;
    @(negedge clock);
    chkb("after_stall_req", imem_req_valid, 1'b1);
    chk("after_stall_addr", imem_req_addr, 32'h208);

    // redirect in WAIT with same-cycle response
    @(negedge clock);
    chkb("wait_no_req", imem_req_valid, 1'b0);
    br_en = 1'b1;
    br_addr = 32'h103;
    @(negedge clock);
    br_en = 1'b0;
    chkb("br_wait_req", imem_req_valid, 1'b1);
    chk("br_wait_addr", imem_req_addr, 32'h100);
    chkb("br_wait_fv", f_valid, 1'b0);
`ifdef FETCH_PERF_EN
    chk("perf_kill1", perf_kill_cnt, 32'd1);
`endif

    // redirect in WAIT before a slow response: kill flag path
    lat = 2;
    @(negedge clock);
    br_en = 1'b1;
    br_addr = 32'h300;
    @(negedge clock);
    br_en = 1'b0;
    chkb("kill_wait_noreq", imem_req_valid, 1'b0);
    wait_cond(1'b0, "kill_req");
    chk("kill_addr", imem_req_addr, 32'h300);
    chkb("kill_fv", f_valid, 1'b0);
`ifdef FETCH_PERF_EN
    chk("perf_kill2", perf_kill_cnt, 32'd2);
`endif

    // retarget before accept, then redirect with same-cycle accept
    lat = 0;
    imem_req_ready = 1'b0;
    br_en = 1'b1;
    br_addr = 32'h500;
    @(negedge clock);
    chkb("retarget_req", imem_req_valid, 1'b1);
    chk("retarget_addr", imem_req_addr, 32'h500);
    imem_req_ready = 1'b1;
    br_addr = 32'h600;
    @(negedge clock);
    br_en = 1'b0;
    chkb("hs_br_wait", imem_req_valid, 1'b0);
    push(32'h600);
    wait_cond(1'b0, "hs_br_req");
    chk("hs_br_addr", imem_req_addr, 32'h600);
`ifdef FETCH_PERF_EN
    chk("perf_kill3", perf_kill_cnt, 32'd3);
`endif
    wait_cond(1'b1, "p600");

    // PC wrap, misaligned target masked
    wait_cond(1'b0, "req604");
    chk("req604_addr", imem_req_addr, 32'h604);
    imem_req_ready = 1'b0;
    br_en = 1'b1;
    br_addr = 32'hFFFF_FFFE;
    @(negedge clock);
    br_en = 1'b0;
    imem_req_ready = 1'b1;
    chk("top_addr", imem_req_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    wait_cond(1'b1, "top_present");
    wait_cond(1'b0, "wrap_req");
    chk("wrap_addr", imem_req_addr, 32'h0);

    // asynchronous reset while waiting on a slow response
    lat = 3;
    @(negedge clock);
    chkb("pre_rst_wait", imem_req_valid, 1'b0);
    #2 reset = 1'b0;
    #1;
    chkb("arst_req_valid", imem_req_valid, 1'b0);
    chkb("arst_f_valid", f_valid, 1'b0);
    chk("arst_f_pc", f_pc_o, 32'h0);
    chk("arst_instr", instr, NOP);
    chk("arst_addr", imem_req_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("arst_perf_stall", perf_stall_cnt, 32'h0);
    chk("arst_perf_kill", perf_kill_cnt, 32'h0);
`endif
    @(negedge clock);
    reset = 1'b1;
    lat = 0;
    push(32'h0);
    wait_cond(1'b0, "post_rst_req");
    chk("post_rst_addr", imem_req_addr, 32'h0);
    wait_cond(1'b1, "post_rst_present");
    @(negedge clock);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
